// File: rtl/noc_mem_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding and default timeout.
package noc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  int   idx;
  logic found;

  // Scan requesters in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising per-CPU requests onto a single memory port.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; arbitrate among req_valid each cycle
// ACK     | req_ready pulsed to winner; its fields are latched at end
// BUSY    | memory strobe held; wait for mem_ready or timeout
module mem_arbiter
  import noc_mem_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                          cpu_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  output logic                          mem_read_en,
  output logic                          mem_write_en,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  input  logic                          mem_ready
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam bit TMR_EN   = (TIMEOUT_CYCLES > 0);
  localparam int TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter reaches zero on the last permitted BUSY cycle.
  localparam int TMR_LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  arb_state_t state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       gid_q, gid_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [NUM_REQ-1:0]    req_ready_d, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d, mem_write_data_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  rsp_err_d, mem_read_en_d, mem_write_en_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_id;
  int                 gidx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  assign gidx = int'(gid_q);

  // Next-state and next-output logic; all outputs are registered copies of these.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    gid_d            = gid_q;
    tmr_d            = tmr_q;
    req_ready_d      = '0;
    rsp_valid_d      = '0;
    rsp_rdata_d      = rsp_rdata;
    rsp_err_d        = rsp_err;
    mem_addr_d       = mem_addr;
    mem_write_data_d = mem_write_data;
    mem_read_en_d    = mem_read_en;
    mem_write_en_d   = mem_write_en;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          gid_d       = arb_id;
          req_ready_d = arb_grant;
          state_d     = ST_ACK;
        end
      end
      ST_ACK: begin
        mem_addr_d       = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write_data_d = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
        mem_read_en_d    = !req_we[gidx];
        mem_write_en_d   = req_we[gidx];
        ptr_d            = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);
        tmr_d            = TMR_W'(TMR_LOAD);
        state_d          = ST_BUSY;
      end
      ST_BUSY: begin
        if (mem_ready) begin
          rsp_valid_d    = NUM_REQ'(1) << gid_q;
          rsp_rdata_d    = mem_write_en ? '0 : mem_read_data;
          rsp_err_d      = 1'b0;
          mem_read_en_d  = 1'b0;
          mem_write_en_d = 1'b0;
          state_d        = ST_IDLE;
        end else if (TMR_EN && (tmr_q == '0)) begin
          rsp_valid_d    = NUM_REQ'(1) << gid_q;
          rsp_rdata_d    = '0;
          rsp_err_d      = 1'b1;
          mem_read_en_d  = 1'b0;
          mem_write_en_d = 1'b0;
          state_d        = ST_IDLE;
        end else if (TMR_EN) begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d        = ST_IDLE;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
      end
    endcase
  end

  // State, pointer, timer and output registers; reset drops any transaction.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      gid_q          <= '0;
      tmr_q          <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gid_q          <= gid_d;
      tmr_q          <= tmr_d;
      req_ready      <= req_ready_d;
      rsp_valid      <= rsp_valid_d;
      rsp_rdata      <= rsp_rdata_d;
      rsp_err        <= rsp_err_d;
      mem_addr       <= mem_addr_d;
      mem_write_data <= mem_write_data_d;
      mem_read_en    <= mem_read_en_d;
      mem_write_en   <= mem_write_en_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic.
module tb_mem_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              cpu_clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_write_data;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DW-1:0]     mem_read_data;
  logic              mem_ready;

  int checks = 0;
  int errors = 0;

  logic [NR-1:0] vld;
  logic [NR-1:0] p_we;
  logic [AW-1:0] p_addr [NR];
  logic [DW-1:0] p_wdata[NR];

  mem_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .cpu_clk        (cpu_clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_wdata[i];
    end
    req_we    = p_we;
    req_valid = vld;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_we[i]    = we;
    p_addr[i]  = a;
    p_wdata[i] = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_write_data, 0);
    chk({tag, "_rd_en"}, mem_read_en, 0);
    chk({tag, "_wr_en"}, mem_write_en, 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    vld       = '0;
    mem_ready = 1'b0;
    drive();
    repeat (2) @(negedge cpu_clk);
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  // Round-robin rule: first pending requester at or after p, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  int            win;
  int            ptr_m;
  int            d;
  bit            served;
  logic [DW-1:0] exp_rd;

  initial begin
    rst_n         = 1'b0;
    vld           = '0;
    p_we          = '0;
    mem_ready     = 1'b0;
    mem_read_data = '0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0);
    drive();

    // Single read by requester 2
    do_reset();
    @(negedge cpu_clk);
    set_req(2, 1'b0, 32'h100, 32'h0);
    vld = 4'b0100;
    drive();
    @(negedge cpu_clk);
    chk("rd_ready_c1", req_ready, 4'b0100);
    chk("rd_no_strobe_c1", mem_read_en, 0);
    @(negedge cpu_clk);
    chk("rd_en_c2", mem_read_en, 1);
    chk("rd_wr_en_c2", mem_write_en, 0);
    chk("rd_addr_c2", mem_addr, 32'h100);
    chk("rd_ready_clear_c2", req_ready, 0);
    vld = '0;
    drive();
    mem_ready     = 1'b1;
    mem_read_data = 32'hCAFEF00D;
    @(negedge cpu_clk);
    chk("rd_rsp_valid_c3", rsp_valid, 4'b0100);
    chk("rd_rsp_rdata_c3", rsp_rdata, 32'hCAFEF00D);
    chk("rd_rsp_err_c3", rsp_err, 0);
    chk("rd_en_off_c3", mem_read_en, 0);
    mem_ready = 1'b0;

    // All four requesters continuously valid, memory always ready
    do_reset();
    @(negedge cpu_clk);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h1000 + i, 32'h0);
    vld       = 4'b1111;
    mem_ready = 1'b1;
    drive();
    for (int c = 1; c <= 14; c++) begin
      @(negedge cpu_clk);
      chk($sformatf("rr_order_c%0d", c), req_ready,
          (c % 3 == 1) ? (4'b0001 << (((c - 1) / 3) % NR)) : 4'b0000);
      chk($sformatf("rr_one_strobe_c%0d", c), mem_read_en & mem_write_en, 0);
    end
    vld = '0;
    drive();
    @(negedge cpu_clk);
    chk("rr_last_rsp", rsp_valid, 4'b0001);
    mem_ready = 1'b0;

    // Write by requester 1 with mem_ready after 5 extra cycles
    @(negedge cpu_clk);
    set_req(1, 1'b1, 32'h40, 32'h12345678);
    vld = 4'b0010;
    drive();
    @(negedge cpu_clk);
    chk("wr_ready", req_ready, 4'b0010);
    for (int j = 0; j < 6; j++) begin
      @(negedge cpu_clk);
      chk($sformatf("wr_en_%0d", j), mem_write_en, 1);
      chk($sformatf("wr_rd_en_%0d", j), mem_read_en, 0);
      chk($sformatf("wr_addr_%0d", j), mem_addr, 32'h40);
      chk($sformatf("wr_data_%0d", j), mem_write_data, 32'h12345678);
      chk($sformatf("wr_no_rsp_%0d", j), rsp_valid, 0);
      if (j == 0) begin
        vld = '0;
        drive();
      end
      mem_ready     = (j == 5);
      mem_read_data = 32'hBEEF0001;
    end
    @(negedge cpu_clk);
    chk("wr_rsp_valid", rsp_valid, 4'b0010);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_en_off", mem_write_en, 0);
    mem_ready = 1'b0;

    // Timeout on requester 3, then requester 0 is served; mem_ready in ACK ignored
    set_req(3, 1'b0, 32'h300, 32'h0);
    set_req(0, 1'b1, 32'h0C0, 32'h55AA55AA);
    vld = 4'b1001;
    drive();
    @(negedge cpu_clk);
    chk("to_ready", req_ready, 4'b1000);
    mem_ready = 1'b1;
    for (int j = 0; j < TO; j++) begin
      @(negedge cpu_clk);
      chk($sformatf("to_rd_en_%0d", j), mem_read_en, 1);
      chk($sformatf("to_no_rsp_%0d", j), rsp_valid, 0);
      if (j == 0) begin
        mem_ready     = 1'b0;
        mem_read_data = 32'hDEADBEEF;
        vld           = 4'b0001;
        drive();
      end
    end
    @(negedge cpu_clk);
    chk("to_rsp_valid", rsp_valid, 4'b1000);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_rd_en_off", mem_read_en, 0);
    @(negedge cpu_clk);
    chk("to_next_ready", req_ready, 4'b0001);
    @(negedge cpu_clk);
    chk("to_next_wr_en", mem_write_en, 1);
    chk("to_next_addr", mem_addr, 32'h0C0);
    vld = '0;
    drive();
    mem_ready = 1'b1;
    @(negedge cpu_clk);
    chk("to_next_rsp", rsp_valid, 4'b0001);
    chk("to_next_err", rsp_err, 0);
    mem_ready = 1'b0;

    // mem_ready arriving on the timeout cycle wins
    set_req(2, 1'b0, 32'h200, 32'h0);
    vld = 4'b0100;
    drive();
    @(negedge cpu_clk);
    chk("tie_ready", req_ready, 4'b0100);
    for (int j = 0; j < TO; j++) begin
      @(negedge cpu_clk);
      chk($sformatf("tie_rd_en_%0d", j), mem_read_en, 1);
      if (j == 0) begin
        vld = '0;
        drive();
      end
      mem_ready     = (j == TO - 1);
      mem_read_data = 32'hA5A51234;
    end
    @(negedge cpu_clk);
    chk("tie_rsp_valid", rsp_valid, 4'b0100);
    chk("tie_rsp_err", rsp_err, 0);
    chk("tie_rsp_rdata", rsp_rdata, 32'hA5A51234);
    mem_ready = 1'b0;

    // Reset during BUSY drops the transaction and restarts the pointer at 0
    set_req(1, 1'b0, 32'h140, 32'h0);
    vld = 4'b0010;
    drive();
    @(negedge cpu_clk);
    chk("rst_ready", req_ready, 4'b0010);
    @(negedge cpu_clk);
    chk("rst_busy_rd_en", mem_read_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_rd_en", mem_read_en, 0);
    chk("rst_async_wr_en", mem_write_en, 0);
    chk("rst_async_addr", mem_addr, 0);
    chk("rst_async_rsp", rsp_valid, 0);
    vld = '0;
    drive();
    mem_ready = 1'b1;
    @(negedge cpu_clk);
    chk("rst_hold_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    @(negedge cpu_clk);
    chk("rst_after_rsp", rsp_valid, 0);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h2000 + i, 32'h0);
    vld = 4'b1111;
    drive();
    @(negedge cpu_clk);
    chk("rst_first_grant", req_ready, 4'b0001);
    @(negedge cpu_clk);
    vld = '0;
    drive();
    @(negedge cpu_clk);
    chk("rst_first_rsp", rsp_valid, 4'b0001);
    mem_ready = 1'b0;

    // Randomized traffic against the transaction-level model
    do_reset();
    @(negedge cpu_clk);
    ptr_m = 0;
    vld   = '0;
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < NR; i++)
        if (!vld[i] && ($urandom_range(1, 0) == 1))
          begin
            set_req(i, 1'($urandom_range(1, 0)), $urandom, $urandom);
            vld[i] = 1'b1;
          end
      drive();
      mem_ready     = 1'($urandom_range(1, 0));
      mem_read_data = $urandom;
      @(negedge cpu_clk);
      if (vld == '0) begin
        chk("rnd_idle_ready", req_ready, 0);
      end else begin
        win = rr_pick(vld, ptr_m);
        chk("rnd_ready", req_ready, 4'b0001 << win);
        chk("rnd_ack_strobe", {mem_read_en, mem_write_en}, 0);
        mem_ready = 1'($urandom_range(1, 0));
        @(negedge cpu_clk);
        vld[win] = 1'b0;
        drive();
        d      = $urandom_range(TO + 1, 0);
        served = 1'b0;
        exp_rd = '0;
        for (int j = 0; j < TO; j++) begin
          if (!served) begin
            if (j > 0) @(negedge cpu_clk);
            chk("rnd_rd_en", mem_read_en, !p_we[win]);
            chk("rnd_wr_en", mem_write_en, p_we[win]);
            chk("rnd_addr", mem_addr, p_addr[win]);
            chk("rnd_wdata", mem_write_data, p_wdata[win]);
            chk("rnd_busy_rsp", rsp_valid, 0);
            mem_ready     = (j == d);
            mem_read_data = $urandom;
            if (j == d) begin
              served = 1'b1;
              exp_rd = p_we[win] ? '0 : mem_read_data;
            end
          end
        end
        @(negedge cpu_clk);
        chk("rnd_rsp_valid", rsp_valid, 4'b0001 << win);
        chk("rnd_rsp_err", rsp_err, !served);
        chk("rnd_rsp_rdata", rsp_rdata, exp_rd);
        chk("rnd_strobe_off", {mem_read_en, mem_write_en}, 0);
        ptr_m = (win + 1) % NR;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
